// File: rtl/accum_ctrl_pkg.sv
// Shared types and default widths for the accumulator-sharing controller.
package accum_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    CLEAR
  } state_t;

  localparam int unsigned DIN_W_DEF  = 8;
  localparam int unsigned DOUT_W_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request strictly
// after ptr, searching upward and wrapping, only while en is high.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    // k runs 1..N so the pointer's own slot is examined last
    for (int unsigned k = 1; k <= N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// Shares one accumulator among N_REQ requesters: round-robin pick, single-cycle
// issue, fixed-latency capture of the running sum, and sequenced clears.
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DIN_W   = DIN_W_DEF,
  parameter int unsigned DOUT_W  = DOUT_W_DEF,
  parameter int unsigned ACC_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DOUT_W-1:0]      rsp_data,
  input  logic                   clr_req,
  output logic                   clr_done,
  output logic                   busy,
  output logic                   acc_rst_b,
  output logic                   acc_din_en,
  output logic [DIN_W-1:0]       acc_din,
  input  logic [DOUT_W-1:0]      acc_dout
);

  localparam int unsigned PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW        = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam int unsigned WAIT_LAST = (ACC_LAT > 1) ? ACC_LAT - 2 : 0;

  state_t            state, state_nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     grant_idx;
  logic [CW-1:0]     wait_cnt;
  logic [DIN_W-1:0]  sel_data;
  logic              arb_en;
  logic              xfer;

  assign arb_en = (state == IDLE) && !clr_req;
  assign xfer   = |req_ready;
  assign busy   = (state != IDLE);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) sel_data = req_data[i*DIN_W +: DIN_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_req)   state_nxt = CLEAR;
        else if (xfer) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (ACC_LAT == 1) state_nxt = CAPTURE;
        else              state_nxt = WAIT;
      end
      WAIT:    if (wait_cnt == CW'(WAIT_LAST)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc_din doubles as the latched winner operand; outputs decode state_nxt so
  // they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= IDLE;
      rr_ptr     <= PW'(N_REQ - 1);
      win_idx    <= '0;
      wait_cnt   <= '0;
      acc_rst_b  <= 1'b0;
      acc_din_en <= 1'b0;
      acc_din    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc_rst_b  <= (state_nxt != CLEAR);
      acc_din_en <= (state_nxt == ISSUE);
      acc_din    <= (state_nxt == ISSUE) ? sel_data : '0;
      clr_done   <= (state == CLEAR);
      rsp_valid  <= '0;
      if (state == IDLE && xfer && !clr_req) win_idx <= grant_idx;
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == CAPTURE) begin
        rsp_data  <= acc_dout;
        rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        rr_ptr    <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl driving a behavioural 2-cycle-latency accumulator.
module tb_accum_ctrl;

  localparam int N_REQ   = 4;
  localparam int DIN_W   = 8;
  localparam int DOUT_W  = 16;
  localparam int ACC_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst_b;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*DIN_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [DOUT_W-1:0]      rsp_data;
  logic                   clr_req;
  logic                   clr_done;
  logic                   busy;
  logic                   acc_rst_b;
  logic                   acc_din_en;
  logic [DIN_W-1:0]       acc_din;
  logic [DOUT_W-1:0]      acc_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int en_cnt = 0;
  int last_en_cyc = 0;
  int rsp_cnt = 0;

  accum_ctrl #(.N_REQ(N_REQ), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .ACC_LAT(ACC_LAT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .clr_req    (clr_req),
    .clr_done   (clr_done),
    .busy       (busy),
    .acc_rst_b  (acc_rst_b),
    .acc_din_en (acc_din_en),
    .acc_din    (acc_din),
    .acc_dout   (acc_dout)
  );

  always #5 clk = ~clk;

  // Accumulator: sum updates on the din_en edge, one more register stage to dout
  logic [DOUT_W-1:0] acc_sum, acc_pipe;
  always @(posedge clk) begin
    if (!acc_rst_b) begin
      acc_sum  <= '0;
      acc_pipe <= '0;
    end else begin
      if (acc_din_en) acc_sum <= acc_sum + {{(DOUT_W-DIN_W){acc_din[DIN_W-1]}}, acc_din};
      acc_pipe <= acc_sum;
    end
  end
  assign acc_dout = acc_pipe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_din_en) begin
      en_cnt      <= en_cnt + 1;
      last_en_cyc <= cyc;
    end
    if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_acc_rst_b"}, acc_rst_b, 0);
    check({tag, "_acc_din_en"}, acc_din_en, 0);
    check({tag, "_acc_din"}, acc_din, 0);
    check({tag, "_clr_done"}, clr_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic reset_dut(input string tag);
    rst_b = 1'b0; req_valid = '0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs(tag);
    rst_b = 1'b1;
    @(negedge clk); #1;
    check({tag, "_acc_rst_b_release"}, acc_rst_b, 1);
  endtask

  // Waits for the next handshake, drops the valids in 'drop', then checks the
  // response: owner, running sum, one din_en cycle, and the issue-to-response gap.
  task automatic serve(input string tag, input int idx, input int exp_sum,
                       input logic [N_REQ-1:0] drop);
    logic [N_REQ-1:0] g, exp_g;
    int e0;
    bit got;
    exp_g = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    g = '0;
    for (int n = 0; n < 40; n++) begin
      #1;
      g = req_ready & req_valid;
      if (g != '0) break;
      @(negedge clk);
    end
    check({tag, "_grant"}, g, exp_g);
    if (g == '0) return;
    e0 = en_cnt;
    @(posedge clk); #1;
    req_valid = req_valid & ~drop;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) begin
        got = 1'b1;
        check({tag, "_rsp_valid"}, rsp_valid, exp_g);
        check({tag, "_rsp_data"}, $signed(rsp_data), exp_sum);
        check({tag, "_din_en_cycles"}, en_cnt - e0, 1);
        // response is ACC_LAT+1 edges after the din_en cycle (the ACC_LAT+2-th cycle)
        check({tag, "_latency"}, cyc - last_en_cyc, ACC_LAT + 1);
      end
    end
    if (!got) check({tag, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic do_clear(input string tag);
    bit seen;
    clr_req = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #1;
      if (clr_done) seen = 1'b1;
    end
    check({tag, "_clr_done_seen"}, seen, 1);
    clr_req = 1'b0;
  endtask

  initial begin
    int rc0;
    rst_b = 1'b0; req_valid = '0; req_data = '0; clr_req = 1'b0;

    // 1: back-to-back singles from requester 0
    reset_dut("t1_rst");
    req_data[0 +: DIN_W] = 8'd5;   req_valid = 4'b0001;
    serve("t1_a", 0, 5, 4'b0001);
    req_data[0 +: DIN_W] = 8'hFD;  req_valid = 4'b0001;
    serve("t1_b", 0, 2, 4'b0001);

    // 2: all four at once, starting from a fresh pointer and sum
    reset_dut("t2_rst");
    req_data = {8'd4, 8'd3, 8'd2, 8'd1};
    req_valid = 4'b1111;
    serve("t2_0", 0, 1, 4'b0001);
    serve("t2_1", 1, 3, 4'b0010);
    serve("t2_2", 2, 6, 4'b0100);
    serve("t2_3", 3, 10, 4'b1000);

    // 3: fairness with 1 and 3 held, 0 joining mid-stream
    req_data = '0;
    req_valid = 4'b1010;
    serve("t3_a", 1, 10, 4'b0000);
    serve("t3_b", 3, 10, 4'b0000);
    serve("t3_c", 1, 10, 4'b0000);
    req_valid[0] = 1'b1;
    serve("t3_d", 3, 10, 4'b0000);
    serve("t3_e", 0, 10, 4'b1111);

    // 4: clear beats a simultaneous request
    req_data[0 +: DIN_W] = 8'd90; req_valid = 4'b0001;
    serve("t4_acc", 0, 100, 4'b0001);
    clr_req = 1'b1;
    req_data[2*DIN_W +: DIN_W] = 8'd7; req_valid = 4'b0100;
    #1;
    check("t4_ready_blocked", req_ready, 0);
    @(negedge clk); #1;
    check("t4_clear_acc_rst_b", acc_rst_b, 0);
    check("t4_clear_busy", busy, 1);
    check("t4_clear_done_early", clr_done, 0);
    @(negedge clk); #1;
    check("t4_after_acc_rst_b", acc_rst_b, 1);
    check("t4_after_clr_done", clr_done, 1);
    check("t4_after_busy", busy, 0);
    clr_req = 1'b0;
    serve("t4_req2", 2, 7, 4'b0100);

    // 5: 258 x 127 = 32766, then +3 wraps to -32767
    do_clear("t5_clr");
    req_data[0 +: DIN_W] = 8'd127; req_valid = 4'b0001;
    for (int k = 1; k <= 258; k++)
      serve("t5_acc", 0, k * 127, (k == 258) ? 4'b0001 : 4'b0000);
    req_data[0 +: DIN_W] = 8'd3; req_valid = 4'b0001;
    serve("t5_wrap", 0, -32767, 4'b0001);

    // 6: reset while waiting on the accumulator
    req_data[3*DIN_W +: DIN_W] = 8'd50; req_valid = 4'b1000;
    #1;
    check("t6_grant", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); @(negedge clk); #1;
    check("t6_wait_busy", busy, 1);
    check("t6_wait_din_en", acc_din_en, 0);
    rc0 = rsp_cnt;
    rst_b = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(negedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk); #1;
    check("t6_acc_rst_b_release", acc_rst_b, 1);
    repeat (4) @(negedge clk);
    #1;
    check("t6_no_rsp", rsp_cnt - rc0, 0);
    req_data[1*DIN_W +: DIN_W] = 8'd9; req_valid = 4'b0010;
    serve("t6_req1", 1, 9, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
